// File: rtl/pcr_pkg.sv
// Shared types and defaults for the host-side PCR initiator.
package pcr_pkg;

    localparam int PCR_ADDR_W = 5;
    localparam int PCR_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } pcr_state_e;

    typedef struct packed {
        logic                  rw;
        logic [PCR_ADDR_W-1:0] addr;
        logic [PCR_DATA_W-1:0] wdata;
    } pcr_req_t;

endpackage

// File: rtl/pcr_timeout_counter.sv
// Saturating wait-cycle counter; expired is high while the count sits at TIMEOUT-1.
module pcr_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_r;

    // Count while enabled; hold at LAST so the count never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r != LAST)) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LAST);

endmodule

// File: rtl/host_pcr_initiator.sv
// Single-outstanding host-to-PCR bridge: latches one host command, issues it to the
// PCR file, waits for the ack (or a timeout) and returns exactly one host response.
module host_pcr_initiator
    import pcr_pkg::*;
#(
    parameter int ADDR_W  = PCR_ADDR_W,
    parameter int DATA_W  = PCR_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  logic              host_req_rw,
    input  logic [ADDR_W-1:0] host_req_addr,
    input  logic [DATA_W-1:0] host_req_wdata,
    output logic              host_resp_valid,
    input  logic              host_resp_ready,
    output logic [DATA_W-1:0] host_resp_data,
    output logic              host_resp_err,
    output logic              pcr_req_valid,
    input  logic              pcr_req_ready,
    output logic              pcr_req_rw,
    output logic [ADDR_W-1:0] pcr_req_addr,
    output logic [DATA_W-1:0] pcr_req_wdata,
    input  logic              pcr_resp_valid,
    input  logic [DATA_W-1:0] pcr_resp_data,
    output logic              busy
);

    pcr_state_e        state_r;
    pcr_state_e        next_s;
    logic              expired_s;
    logic              rw_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] resp_data_r;
    logic              resp_err_r;

    pcr_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_r != WAIT),
        .enable  (state_r == WAIT),
        .expired (expired_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode; an ack in the timeout cycle still takes the RESP path as a success.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE:    next_s = host_req_valid ? ISSUE : IDLE;
            ISSUE:   next_s = pcr_req_ready ? WAIT : ISSUE;
            WAIT:    next_s = (pcr_resp_valid || expired_s) ? RESP : WAIT;
            RESP:    next_s = host_resp_ready ? IDLE : RESP;
            default: next_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only.
    always_comb begin
        host_req_ready  = 1'b0;
        pcr_req_valid   = 1'b0;
        host_resp_valid = 1'b0;
        busy            = 1'b1;
        case (state_r)
            IDLE: begin
                host_req_ready = 1'b1;
                busy           = 1'b0;
            end
            ISSUE:   pcr_req_valid   = 1'b1;
            WAIT:    busy            = 1'b1;
            RESP:    host_resp_valid = 1'b1;
            default: busy            = 1'b0;
        endcase
    end

    // Request latch; write data is zeroed for reads so the PCR bus never carries stale data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rw_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
        end else if ((state_r == IDLE) && host_req_valid) begin
            rw_r    <= host_req_rw;
            addr_r  <= host_req_addr;
            wdata_r <= host_req_rw ? host_req_wdata : {DATA_W{1'b0}};
        end else begin
            rw_r    <= rw_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Response register; only written in WAIT so stray acks elsewhere leave it untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_data_r <= {DATA_W{1'b0}};
            resp_err_r  <= 1'b0;
        end else if ((state_r == WAIT) && pcr_resp_valid) begin
            resp_data_r <= rw_r ? {DATA_W{1'b0}} : pcr_resp_data;
            resp_err_r  <= 1'b0;
        end else if ((state_r == WAIT) && expired_s) begin
            resp_data_r <= {DATA_W{1'b0}};
            resp_err_r  <= 1'b1;
        end else if ((state_r == RESP) && host_resp_ready) begin
            resp_data_r <= {DATA_W{1'b0}};
            resp_err_r  <= 1'b0;
        end else begin
            resp_data_r <= resp_data_r;
            resp_err_r  <= resp_err_r;
        end
    end

    assign pcr_req_rw     = rw_r;
    assign pcr_req_addr   = addr_r;
    assign pcr_req_wdata  = wdata_r;
    assign host_resp_data = resp_data_r;
    assign host_resp_err  = resp_err_r;

endmodule

// File: tb/tb_host_pcr_initiator.sv
// Directed self-checking bench for host_pcr_initiator (TIMEOUT = 16).
module tb_host_pcr_initiator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        host_req_valid;
    logic        host_req_ready;
    logic        host_req_rw;
    logic [4:0]  host_req_addr;
    logic [63:0] host_req_wdata;
    logic        host_resp_valid;
    logic        host_resp_ready;
    logic [63:0] host_resp_data;
    logic        host_resp_err;
    logic        pcr_req_valid;
    logic        pcr_req_ready;
    logic        pcr_req_rw;
    logic [4:0]  pcr_req_addr;
    logic [63:0] pcr_req_wdata;
    logic        pcr_resp_valid;
    logic [63:0] pcr_resp_data;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    host_pcr_initiator #(.ADDR_W(5), .DATA_W(64), .TIMEOUT(16)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .host_req_valid  (host_req_valid),
        .host_req_ready  (host_req_ready),
        .host_req_rw     (host_req_rw),
        .host_req_addr   (host_req_addr),
        .host_req_wdata  (host_req_wdata),
        .host_resp_valid (host_resp_valid),
        .host_resp_ready (host_resp_ready),
        .host_resp_data  (host_resp_data),
        .host_resp_err   (host_resp_err),
        .pcr_req_valid   (pcr_req_valid),
        .pcr_req_ready   (pcr_req_ready),
        .pcr_req_rw      (pcr_req_rw),
        .pcr_req_addr    (pcr_req_addr),
        .pcr_req_wdata   (pcr_req_wdata),
        .pcr_resp_valid  (pcr_resp_valid),
        .pcr_resp_data   (pcr_resp_data),
        .busy            (busy)
    );

    task automatic test_reset;
        reset_n = 1'b0; host_req_valid = 1'b0; host_req_rw = 1'b0; host_req_addr = 5'h00;
        host_req_wdata = 64'h0; host_resp_ready = 1'b1; pcr_req_ready = 1'b0;
        pcr_resp_valid = 1'b0; pcr_resp_data = 64'h0;
        repeat (2) @(negedge clk);
        tests++; if (host_req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %0b exp 1", host_req_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b exp 0", busy); end
        tests++; if (pcr_req_valid !== 1'b0) begin fails++; $display("FAIL reset_pcr_valid got %0b exp 0", pcr_req_valid); end
        tests++; if (host_resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %0b exp 0", host_resp_valid); end
        tests++; if (host_resp_data !== 64'h0 || host_resp_err !== 1'b0) begin fails++; $display("FAIL reset_resp_regs got %0h/%0b exp 0/0", host_resp_data, host_resp_err); end
        tests++; if (pcr_req_rw !== 1'b0 || pcr_req_addr !== 5'h00 || pcr_req_wdata !== 64'h0) begin fails++; $display("FAIL reset_latch got %0b/%0h/%0h exp 0/0/0", pcr_req_rw, pcr_req_addr, pcr_req_wdata); end
        reset_n = 1'b1;
        @(negedge clk);
        tests++; if (host_req_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL post_reset_idle got ready %0b busy %0b exp 1/0", host_req_ready, busy); end
    endtask

    task automatic test_read;
        host_req_valid = 1'b1; host_req_rw = 1'b0; host_req_addr = 5'h04;
        host_req_wdata = 64'hFFFF_0000_1111_2222; pcr_req_ready = 1'b0;
        @(negedge clk);
        host_req_valid = 1'b0;
        tests++; if (pcr_req_valid !== 1'b1 || host_req_ready !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL read_issue_hs got pv %0b hr %0b busy %0b exp 1/0/1", pcr_req_valid, host_req_ready, busy); end
        tests++; if (pcr_req_rw !== 1'b0 || pcr_req_addr !== 5'h04 || pcr_req_wdata !== 64'h0) begin fails++; $display("FAIL read_issue_fields got %0b/%0h/%0h exp 0/4/0", pcr_req_rw, pcr_req_addr, pcr_req_wdata); end
        @(negedge clk);
        tests++; if (pcr_req_valid !== 1'b1) begin fails++; $display("FAIL read_issue_hold got %0b exp 1", pcr_req_valid); end
        pcr_req_ready = 1'b1;
        @(negedge clk);
        pcr_req_ready = 1'b0;
        tests++; if (pcr_req_valid !== 1'b0 || busy !== 1'b1 || host_resp_valid !== 1'b0) begin fails++; $display("FAIL read_wait got pv %0b busy %0b rv %0b exp 0/1/0", pcr_req_valid, busy, host_resp_valid); end
        @(negedge clk);
        pcr_resp_valid = 1'b1; pcr_resp_data = 64'hDEAD_BEEF;
        @(negedge clk);
        pcr_resp_valid = 1'b0; pcr_resp_data = 64'h0;
        tests++; if (host_resp_valid !== 1'b1 || host_resp_data !== 64'hDEAD_BEEF || host_resp_err !== 1'b0) begin fails++; $display("FAIL read_resp got v %0b d %0h e %0b exp 1/deadbeef/0", host_resp_valid, host_resp_data, host_resp_err); end
        @(negedge clk);
        tests++; if (host_resp_valid !== 1'b0 || host_req_ready !== 1'b1) begin fails++; $display("FAIL read_done got rv %0b hr %0b exp 0/1", host_resp_valid, host_req_ready); end
    endtask

    task automatic test_write;
        host_req_valid = 1'b1; host_req_rw = 1'b1; host_req_addr = 5'h1F;
        host_req_wdata = 64'h0123_4567_89AB_CDEF; pcr_req_ready = 1'b1;
        @(negedge clk);
        host_req_valid = 1'b0;
        tests++; if (pcr_req_valid !== 1'b1 || pcr_req_rw !== 1'b1 || pcr_req_addr !== 5'h1F || pcr_req_wdata !== 64'h0123_4567_89AB_CDEF) begin fails++; $display("FAIL write_issue got %0b/%0b/%0h/%0h exp 1/1/1f/123456789abcdef", pcr_req_valid, pcr_req_rw, pcr_req_addr, pcr_req_wdata); end
        @(negedge clk);
        pcr_req_ready = 1'b0; pcr_resp_valid = 1'b1; pcr_resp_data = 64'hAAAA_5555_AAAA_5555;
        @(negedge clk);
        pcr_resp_valid = 1'b0; pcr_resp_data = 64'h0;
        tests++; if (host_resp_valid !== 1'b1 || host_resp_data !== 64'h0 || host_resp_err !== 1'b0) begin fails++; $display("FAIL write_resp got v %0b d %0h e %0b exp 1/0/0", host_resp_valid, host_resp_data, host_resp_err); end
        @(negedge clk);
        tests++; if (host_resp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL write_done got rv %0b busy %0b exp 0/0", host_resp_valid, busy); end
    endtask

    task automatic test_timeout;
        int c;
        bit got;
        host_req_valid = 1'b1; host_req_rw = 1'b0; host_req_addr = 5'h03;
        pcr_req_ready = 1'b1; host_resp_ready = 1'b0;
        @(negedge clk);
        host_req_valid = 1'b0;
        tests++; if (pcr_req_valid !== 1'b1) begin fails++; $display("FAIL tmo_issue got %0b exp 1", pcr_req_valid); end
        c = 0; got = 1'b0;
        while (c < 40 && !got) begin
            @(negedge clk);
            pcr_req_ready = 1'b0;
            c++;
            if (host_resp_valid === 1'b1) got = 1'b1;
        end
        tests++; if (got !== 1'b1) begin fails++; $display("FAIL tmo_no_resp got none within %0d cycles exp resp", c); end
        tests++; if (c - 1 !== 16) begin fails++; $display("FAIL tmo_latency got %0d cycles exp 16", c - 1); end
        tests++; if (host_resp_err !== 1'b1 || host_resp_data !== 64'h0) begin fails++; $display("FAIL tmo_err got e %0b d %0h exp 1/0", host_resp_err, host_resp_data); end
        pcr_resp_valid = 1'b1; pcr_resp_data = 64'h1234_5678;
        @(negedge clk);
        pcr_resp_valid = 1'b0; pcr_resp_data = 64'h0;
        tests++; if (host_resp_valid !== 1'b1 || host_resp_err !== 1'b1 || host_resp_data !== 64'h0) begin fails++; $display("FAIL tmo_late_ack got v %0b e %0b d %0h exp 1/1/0", host_resp_valid, host_resp_err, host_resp_data); end
        host_resp_ready = 1'b1;
        @(negedge clk);
        tests++; if (host_resp_valid !== 1'b0 || host_req_ready !== 1'b1) begin fails++; $display("FAIL tmo_done got rv %0b hr %0b exp 0/1", host_resp_valid, host_req_ready); end
        pcr_resp_valid = 1'b1; pcr_resp_data = 64'h9999;
        @(negedge clk);
        pcr_resp_valid = 1'b0; pcr_resp_data = 64'h0;
        tests++; if (busy !== 1'b0 || host_resp_valid !== 1'b0 || host_resp_data !== 64'h0) begin fails++; $display("FAIL idle_stray got busy %0b rv %0b d %0h exp 0/0/0", busy, host_resp_valid, host_resp_data); end
    endtask

    task automatic test_race;
        int c;
        bit got;
        host_req_valid = 1'b1; host_req_rw = 1'b0; host_req_addr = 5'h07;
        pcr_req_ready = 1'b1; host_resp_ready = 1'b1; pcr_resp_data = 64'hCAFE_F00D_0000_0001;
        @(negedge clk);
        host_req_valid = 1'b0;
        c = 0; got = 1'b0;
        while (c < 40 && !got) begin
            @(negedge clk);
            pcr_req_ready = 1'b0;
            c++;
            pcr_resp_valid = (c == 16);
            if (host_resp_valid === 1'b1) got = 1'b1;
        end
        pcr_resp_valid = 1'b0;
        tests++; if (got !== 1'b1 || c !== 17) begin fails++; $display("FAIL race_latency got %0b at %0d exp 1 at 17", got, c); end
        tests++; if (host_resp_err !== 1'b0 || host_resp_data !== 64'hCAFE_F00D_0000_0001) begin fails++; $display("FAIL race_resp got e %0b d %0h exp 0/cafef00d00000001", host_resp_err, host_resp_data); end
        @(negedge clk);
        tests++; if (host_resp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL race_done got rv %0b busy %0b exp 0/0", host_resp_valid, busy); end
    endtask

    task automatic test_back_to_back;
        host_resp_ready = 1'b0;
        host_req_valid = 1'b1; host_req_rw = 1'b0; host_req_addr = 5'h0A; pcr_req_ready = 1'b1;
        @(negedge clk);
        host_req_valid = 1'b0;
        @(negedge clk);
        pcr_req_ready = 1'b0; pcr_resp_valid = 1'b1; pcr_resp_data = 64'h5A5A_0000_FFFF_0001;
        @(negedge clk);
        pcr_resp_valid = 1'b0; pcr_resp_data = 64'h0;
        host_req_valid = 1'b1; host_req_rw = 1'b1; host_req_addr = 5'h11; host_req_wdata = 64'h77;
        for (int i = 0; i < 5; i++) begin
            tests++; if (host_resp_valid !== 1'b1 || host_resp_data !== 64'h5A5A_0000_FFFF_0001 || host_resp_err !== 1'b0) begin fails++; $display("FAIL bp_hold[%0d] got v %0b d %0h e %0b exp 1/5a5a0000ffff0001/0", i, host_resp_valid, host_resp_data, host_resp_err); end
            tests++; if (host_req_ready !== 1'b0 || pcr_req_valid !== 1'b0 || pcr_req_addr !== 5'h0A) begin fails++; $display("FAIL bp_block[%0d] got hr %0b pv %0b a %0h exp 0/0/a", i, host_req_ready, pcr_req_valid, pcr_req_addr); end
            @(negedge clk);
        end
        host_resp_ready = 1'b1;
        @(negedge clk);
        tests++; if (host_resp_valid !== 1'b0 || host_req_ready !== 1'b1) begin fails++; $display("FAIL bp_release got rv %0b hr %0b exp 0/1", host_resp_valid, host_req_ready); end
        @(negedge clk);
        host_req_valid = 1'b0;
        tests++; if (pcr_req_valid !== 1'b1 || pcr_req_rw !== 1'b1 || pcr_req_addr !== 5'h11 || pcr_req_wdata !== 64'h77) begin fails++; $display("FAIL bp_next_issue got %0b/%0b/%0h/%0h exp 1/1/11/77", pcr_req_valid, pcr_req_rw, pcr_req_addr, pcr_req_wdata); end
        pcr_req_ready = 1'b1;
        @(negedge clk);
        pcr_req_ready = 1'b0; pcr_resp_valid = 1'b1; pcr_resp_data = 64'h4444;
        @(negedge clk);
        pcr_resp_valid = 1'b0; pcr_resp_data = 64'h0;
        tests++; if (host_resp_valid !== 1'b1 || host_resp_data !== 64'h0 || host_resp_err !== 1'b0) begin fails++; $display("FAIL bp_next_resp got v %0b d %0h e %0b exp 1/0/0", host_resp_valid, host_resp_data, host_resp_err); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        host_req_valid = 1'b1; host_req_rw = 1'b0; host_req_addr = 5'h02; pcr_req_ready = 1'b1;
        @(negedge clk);
        host_req_valid = 1'b0;
        @(negedge clk);
        pcr_req_ready = 1'b0;
        tests++; if (busy !== 1'b1 || pcr_req_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_wait got busy %0b pv %0b exp 1/0", busy, pcr_req_valid); end
        reset_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0 || pcr_req_valid !== 1'b0 || host_req_ready !== 1'b1 || host_resp_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_async got busy %0b pv %0b hr %0b rv %0b exp 0/0/1/0", busy, pcr_req_valid, host_req_ready, host_resp_valid); end
        @(negedge clk);
        reset_n = 1'b1; pcr_resp_valid = 1'b1; pcr_resp_data = 64'hBAD0;
        @(negedge clk);
        pcr_resp_valid = 1'b0; pcr_resp_data = 64'h0;
        repeat (2) @(negedge clk);
        tests++; if (host_resp_valid !== 1'b0 || busy !== 1'b0 || host_resp_data !== 64'h0) begin fails++; $display("FAIL rst_mid_noresp got rv %0b busy %0b d %0h exp 0/0/0", host_resp_valid, busy, host_resp_data); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_race();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
